// File: rtl/blink_phase_recover_if.sv
// Blink line plus shared count in, recovered phase and status out.
// BLINK_FALL_CHECK_EN adds the fall_err status pulse.
interface blink_phase_recover_if #(
   parameter int CNT_W = 16
);
   logic             blink_in;
   logic [CNT_W-1:0] currentCount;
   logic [CNT_W-1:0] offset_out;
   logic             locked;
   logic             offset_upd;
   logic             lost;
`ifdef BLINK_FALL_CHECK_EN
   logic             fall_err;

   modport master (
      output blink_in, currentCount,
      input  offset_out, locked, offset_upd, lost, fall_err
   );
   modport slave (
      input  blink_in, currentCount,
      output offset_out, locked, offset_upd, lost, fall_err
   );
`else
   modport master (
      output blink_in, currentCount,
      input  offset_out, locked, offset_upd, lost
   );
   modport slave (
      input  blink_in, currentCount,
      output offset_out, locked, offset_upd, lost
   );
`endif
endinterface

// File: rtl/blink_phase_recover.sv
// Recovers the blink generator offset mod 2^(BLINK_BIT+1) and qualifies lock.
// BLINK_FALL_CHECK_EN also checks falling edges and drives fall_err.
module blink_phase_recover #(
   parameter int CNT_W       = 16,
   parameter int BLINK_BIT   = 9,
   parameter int SYNC_STAGES = 2,
   parameter int LOCK_CNT    = 3,
   parameter int TOL         = 0,
   parameter int TIMEOUT_CYC = 4096
) (
   input logic            clk,
   input logic            rst,
   blink_phase_recover_if.slave bus
);
   localparam int W  = BLINK_BIT + 1;
   localparam int MW = $clog2(LOCK_CNT + 1);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [W-1:0]  HALF   = W'(1) << (W - 1);
   localparam logic [W:0]    TOL_W  = (W + 1)'(TOL);
   localparam logic [MW-1:0] LOCK_M = MW'(LOCK_CNT);
   localparam logic [MW-1:0] ONE_M  = MW'(1);
   localparam logic [TW-1:0] ONE_T  = TW'(1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      TRACK  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic near(
      input logic [W-1:0] a,
      input logic [W-1:0] b
   );
      logic [W-1:0] d_ab;
      logic [W-1:0] d_ba;
      logic [W-1:0] d_min;
      d_ab  = a - b;
      d_ba  = b - a;
      d_min = (d_ab < d_ba) ? d_ab : d_ba;
      return {1'b0, d_min} <= TOL_W;
   endfunction

   logic [SYNC_STAGES-1:0] sync_q;
   logic [W-1:0]           cnt_q [SYNC_STAGES];
   logic                   prev_q;

   // Count rides alongside blink so each sample keeps its own timestamp
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
         for (int i = 0; i < SYNC_STAGES; i++) cnt_q[i] <= '0;
      end else begin
         sync_q   <= {sync_q[SYNC_STAGES-2:0], bus.blink_in};
         cnt_q[0] <= bus.currentCount[W-1:0];
         for (int i = 1; i < SYNC_STAGES; i++) cnt_q[i] <= cnt_q[i-1];
         prev_q   <= sync_q[SYNC_STAGES-1];
      end
   end

   generate
      if (CNT_W > W) begin : g_hi
         logic cnt_hi_unused;
         assign cnt_hi_unused = ^bus.currentCount[CNT_W-1:W];
      end
   endgenerate

   state_t        state_q, state_d;
   logic [W-1:0]  cand_q, cand_d;
   logic [W-1:0]  off_q, off_d;
   logic [MW-1:0] mcnt_q, mcnt_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          upd_q, upd_d;
   logic          lost_q, lost_d;

   logic          sync_s;
   logic          rise;
   logic [W-1:0]  cp;
   logic [W-1:0]  est_r;
   logic          match_r;

   assign sync_s  = sync_q[SYNC_STAGES-1];
   assign rise    = sync_s & ~prev_q;
   assign cp      = cnt_q[SYNC_STAGES-1];
   assign est_r   = HALF - cp;
   assign match_r = near(est_r, cand_q);

`ifdef BLINK_FALL_CHECK_EN
   logic          ferr_q, ferr_d;
   logic          fall;
   logic [W-1:0]  est_f;
   logic          match_f;

   assign fall    = ~sync_s & prev_q;
   assign est_f   = '0 - cp;
   assign match_f = near(est_f, cand_q);
`endif

   always_comb begin
      state_d = state_q;
      cand_d  = cand_q;
      off_d   = off_q;
      mcnt_d  = mcnt_q;
      timer_d = timer_q;
      upd_d   = 1'b0;
      lost_d  = 1'b0;
`ifdef BLINK_FALL_CHECK_EN
      ferr_d  = 1'b0;
`endif
      unique case (state_q)
         SEARCH: begin
            if (rise) begin
               cand_d  = est_r;
               mcnt_d  = ONE_M;
               state_d = TRACK;
               if (ONE_M >= LOCK_M) begin
                  state_d = LOCKED;
                  off_d   = est_r;
                  upd_d   = 1'b1;
                  timer_d = '0;
               end
            end
         end
         TRACK: begin
            if (rise && match_r) begin
               if (mcnt_q + ONE_M >= LOCK_M) begin
                  state_d = LOCKED;
                  off_d   = cand_q;
                  upd_d   = 1'b1;
                  timer_d = '0;
               end else begin
                  mcnt_d = mcnt_q + ONE_M;
               end
            end else if (rise) begin
               cand_d = est_r;
               mcnt_d = ONE_M;
               if (ONE_M >= LOCK_M) begin
                  state_d = LOCKED;
                  off_d   = est_r;
                  upd_d   = 1'b1;
                  timer_d = '0;
               end
            end
`ifdef BLINK_FALL_CHECK_EN
            else if (fall && !match_f) begin
               mcnt_d = '0;
               ferr_d = 1'b1;
            end
`endif
         end
         LOCKED: begin
            // A rising edge always takes priority over timeout expiry
            if (rise && match_r) begin
               timer_d = '0;
            end else if (rise) begin
               state_d = TRACK;
               cand_d  = est_r;
               mcnt_d  = ONE_M;
               lost_d  = 1'b1;
            end
`ifdef BLINK_FALL_CHECK_EN
            else if (fall && !match_f) begin
               state_d = TRACK;
               cand_d  = est_f;
               mcnt_d  = ONE_M;
               lost_d  = 1'b1;
               ferr_d  = 1'b1;
            end
`endif
            else if (timer_q == T_LAST) begin
               state_d = SEARCH;
               lost_d  = 1'b1;
            end else begin
               timer_d = timer_q + ONE_T;
            end
         end
         default: state_d = SEARCH;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= SEARCH;
         cand_q  <= '0;
         off_q   <= '0;
         mcnt_q  <= '0;
         timer_q <= '0;
         upd_q   <= 1'b0;
         lost_q  <= 1'b0;
`ifdef BLINK_FALL_CHECK_EN
         ferr_q  <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         cand_q  <= cand_d;
         off_q   <= off_d;
         mcnt_q  <= mcnt_d;
         timer_q <= timer_d;
         upd_q   <= upd_d;
         lost_q  <= lost_d;
`ifdef BLINK_FALL_CHECK_EN
         ferr_q  <= ferr_d;
`endif
      end
   end

   assign bus.offset_out = CNT_W'(off_q);
   assign bus.locked     = (state_q == LOCKED);
   assign bus.offset_upd = upd_q;
   assign bus.lost       = lost_q;
`ifdef BLINK_FALL_CHECK_EN
   assign bus.fall_err   = ferr_q;
`endif
endmodule

// File: tb/tb_blink_phase_recover.sv
// Bench for blink_phase_recover: directed phases plus random count stepping,
// checked every cycle against an edge-level reference model.
module tb_blink_phase_recover;
   localparam int CNT_W = 16;
   localparam int BB    = 9;
   localparam int S     = 2;
   localparam int LOCK  = 3;
   localparam int TOL   = 0;
   localparam int TMO   = 4096;
   localparam int P     = 1 << (BB + 1);
   localparam int MAXS  = 40000;

   logic clk = 1'b0;
   logic rst = 1'b1;

   blink_phase_recover_if #(.CNT_W(CNT_W)) bus ();

   blink_phase_recover #(
      .CNT_W(CNT_W), .BLINK_BIT(BB), .SYNC_STAGES(S),
      .LOCK_CNT(LOCK), .TOL(TOL), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int step = 0;

   int e_lock [MAXS];
   int e_off  [MAXS];
   int e_upd  [MAXS];
   int e_lost [MAXS];
`ifdef BLINK_FALL_CHECK_EN
   int e_ferr [MAXS];
   int m_ferr;
`endif

   int m_state, m_cand, m_cnt, m_off, m_reload;
   int m_upd, m_lost;
   bit m_prev;

   int cnt = 0;
   int src_off = 0;
   bit irreg = 0, force0 = 0, early = 0, src_prev = 0;
   int upd_at = -1, lost_at = -1, off_at_lost = -1;
   int upd_n = 0, lost_n = 0, ferr_n = 0, rise_n = 0;
   int last_rise = -1, upd_rises = -1, base = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   function automatic int cdist(input int a, input int b);
      int d;
      d = ((a - b) % P + P) % P;
      return (d < P - d) ? d : P - d;
   endfunction

   task automatic mreset();
      m_state = 0; m_cand = 0; m_cnt = 0; m_off = 0;
      m_reload = 0; m_upd = 0; m_lost = 0; m_prev = 0;
`ifdef BLINK_FALL_CHECK_EN
      m_ferr = 0;
`endif
   endtask

   task automatic mstep(input int s, input bit b, input int c);
      bit rise;
      int cl, er;
`ifdef BLINK_FALL_CHECK_EN
      bit fall;
      int ef;
      fall = !b && m_prev;
      ef = (P - c % P) % P;
      m_ferr = 0;
`endif
      rise = b && !m_prev;
      m_prev = b;
      cl = c % P;
      er = (P / 2 - cl + P) % P;
      m_upd = 0;
      m_lost = 0;
      if (m_state == 0) begin
         if (rise) begin m_cand = er; m_cnt = 1; m_state = 1; end
      end else if (m_state == 1) begin
         if (rise) begin
            if (cdist(er, m_cand) <= TOL) m_cnt++;
            else begin m_cand = er; m_cnt = 1; end
         end
`ifdef BLINK_FALL_CHECK_EN
         else if (fall && cdist(ef, m_cand) > TOL) begin
            m_cnt = 0; m_ferr = 1;
         end
`endif
      end else begin
         if (rise) begin
            if (cdist(er, m_cand) <= TOL) m_reload = s;
            else begin
               m_state = 1; m_cand = er; m_cnt = 1; m_lost = 1;
            end
         end
`ifdef BLINK_FALL_CHECK_EN
         else if (fall && cdist(ef, m_cand) > TOL) begin
            m_state = 1; m_cand = ef; m_cnt = 1;
            m_lost = 1; m_ferr = 1;
         end
`endif
         else if (s - m_reload >= TMO) begin
            m_state = 0; m_lost = 1;
         end
      end
      if (rise && m_state == 1 && m_cnt >= LOCK && !m_lost) begin
         m_state = 2; m_off = m_cand; m_upd = 1; m_reload = s;
      end
   endtask

   task automatic record(input int s);
      if (s >= MAXS) begin
         $display("FAIL step_budget observed=%0d required<%0d", s, MAXS);
         $fatal(1, "step budget exceeded");
      end
      e_lock[s] = (m_state == 2) ? 1 : 0;
      e_off[s]  = m_off;
      e_upd[s]  = m_upd;
      e_lost[s] = m_lost;
`ifdef BLINK_FALL_CHECK_EN
      e_ferr[s] = m_ferr;
`endif
   endtask

   task automatic zero(input int k);
      e_lock[k] = 0; e_off[k] = 0; e_upd[k] = 0; e_lost[k] = 0;
`ifdef BLINK_FALL_CHECK_EN
      e_ferr[k] = 0;
`endif
   endtask

   task automatic cycle(input bit rv);
      int idx;
      bit b;
      @(negedge clk);
      if (rv && !rst)
         for (int k = step - 1 - S; k < step; k++)
            if (k >= 0) zero(k);
      rst = rv;
      #1;
      idx = step - 1 - S;
      chk("locked", bus.locked, idx >= 0 ? e_lock[idx] : 0);
      chk("offset_out", bus.offset_out, idx >= 0 ? e_off[idx] : 0);
      chk("offset_upd", bus.offset_upd, idx >= 0 ? e_upd[idx] : 0);
      chk("lost", bus.lost, idx >= 0 ? e_lost[idx] : 0);
`ifdef BLINK_FALL_CHECK_EN
      chk("fall_err", bus.fall_err, idx >= 0 ? e_ferr[idx] : 0);
      if (bus.fall_err === 1'b1) ferr_n++;
`endif
      if (bus.offset_upd === 1'b1) begin
         upd_at = step; upd_n++; upd_rises = rise_n;
      end
      if (bus.lost === 1'b1) begin
         lost_at = step; lost_n++; off_at_lost = int'(bus.offset_out);
      end
      b = (((cnt + src_off) % P) >= P / 2);
      if (force0) b = 0;
      if (early && ((cnt + src_off) % P) >= P - 5) b = 0;
      if (b && !src_prev) begin rise_n++; last_rise = step; end
      src_prev = b;
      bus.blink_in = b;
      bus.currentCount = 16'(cnt);
      if (rv) mreset();
      else mstep(step, b, cnt);
      record(step);
      step++;
      cnt = (cnt + ((irreg && $urandom_range(0, 3) == 0) ? 0 : 1)) % 65536;
   endtask

   initial begin
      bus.blink_in = 1'b0;
      bus.currentCount = '0;
      mreset();

      repeat (3) cycle(1);
      cnt = 0; src_off = 100; base = step; upd_n = 0; lost_n = 0;
      while (cnt < 3000) cycle(0);
      chk("t1_locked", bus.locked, 1);
      chk("t1_offset", bus.offset_out, 100);
      chk("t1_upd_n", upd_n, 1);
      chk("t1_upd_step", upd_at, base + 2460 + S + 1);

      src_off = 300; upd_n = 0; lost_n = 0;
      while (cnt < 5600) cycle(0);
      chk("t2_lost_step", lost_at, base + 3284 + S + 1);
      chk("t2_lost_n", lost_n, 1);
      chk("t2_off_held", off_at_lost, 100);
      chk("t2_upd_step", upd_at, base + 5332 + S + 1);
      chk("t2_offset", bus.offset_out, 300);

      repeat (2) cycle(1);
      cnt = 16'hFF00; src_off = 1000; base = step;
      upd_n = 0; lost_n = 0;
      repeat (3000) cycle(0);
      chk("t3_offset", bus.offset_out, 16'h03E8);
      chk("t3_locked", bus.locked, 1);
      chk("t3_lost_n", lost_n, 0);
      chk("t3_upd_step", upd_at, base + 2840 + S + 1);

      for (int i = 0; i < 2000 && src_prev; i++) cycle(0);
      force0 = 1; lost_n = 0;
      repeat (TMO + 200) cycle(0);
      chk("t4_lost_n", lost_n, 1);
      chk("t4_lost_step", lost_at, last_rise + TMO + S + 1);
      chk("t4_locked", bus.locked, 0);
      force0 = 0;

      repeat (2) cycle(1);
      cnt = 0; src_off = 200;
      while (cnt < 2000) cycle(0);
      chk("t5_pre_locked", bus.locked, 0);
      cycle(1);
      chk("t5_rst_locked", bus.locked, 0);
      chk("t5_rst_upd", bus.offset_upd, 0);
      cycle(1);
      rise_n = 0; upd_n = 0; upd_rises = -1;
      for (int i = 0; i < 5000 && upd_n == 0; i++) cycle(0);
      chk("t5_lock_seen", upd_n, 1);
      chk("t5_rises", upd_rises, 3);
      chk("t5_offset", bus.offset_out, 200);

`ifdef BLINK_FALL_CHECK_EN
      for (int i = 0; i < 3000 && ((cnt + src_off) % P) != P - 20; i++)
         cycle(0);
      ferr_n = 0; lost_n = 0;
      early = 1;
      repeat (40) cycle(0);
      early = 0;
      chk("t6_ferr_n", ferr_n, 1);
      chk("t6_lost_n", lost_n, 1);
      chk("t6_locked", bus.locked, 0);
`endif

      repeat (2) cycle(1);
      cnt = $urandom_range(0, 65535);
      src_off = $urandom_range(0, P - 1);
      irreg = 1;
      for (int seg = 0; seg < 8; seg++) begin
         repeat (1000) cycle(0);
         if ($urandom_range(0, 1) == 1)
            src_off = (src_off + $urandom_range(1, 3)) % P;
         else
            src_off = $urandom_range(0, P - 1);
      end
      irreg = 0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
